// File: rtl/ro_meas_pkg.sv
// Shared FSM type, encoding width and default sizing for the ring-oscillator
// measurement controller.
package ro_meas_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GATE   = 2'd2,
    ST_DONE   = 2'd3
  } ro_state_e;

  localparam int DEF_NUM_RO        = 8;
  localparam int DEF_SEL_W         = 3;
  localparam int DEF_GATE_W        = 16;
  localparam int DEF_CNT_W         = 24;
  localparam int DEF_SETTLE_CYCLES = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// Two-flop synchronizer plus delay flop; emits a one-cycle pulse on each
// synchronized rising edge of an asynchronous input.
module ro_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic r_s1, r_s2, r_s3;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign rise = r_s2 & ~r_s3;

endmodule

// File: rtl/ro_measure_ctrl.sv
// Ring-oscillator measurement controller: enable one ring, settle, count its
// edges over a gate. Optional back-to-back sweep of all rings via RO_SWEEP_EN.
module ro_measure_ctrl
  import ro_meas_pkg::*;
#(
  parameter int NUM_RO        = DEF_NUM_RO,
  parameter int SEL_W         = DEF_SEL_W,
  parameter int GATE_W        = DEF_GATE_W,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SEL_W-1:0]  ro_sel,
  input  logic [GATE_W-1:0] gate_len,
`ifdef RO_SWEEP_EN
  input  logic              sweep,
  output logic              sweep_done,
`endif
  output logic [NUM_RO-1:0] ro_en,
  input  logic [NUM_RO-1:0] ro_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic [SEL_W-1:0]  count_idx,
  output logic              overflow,
  output logic              sel_err
);

  localparam int TMR_W = max_int(GATE_W, $clog2(SETTLE_CYCLES + 1));
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
  localparam logic [SEL_W:0]   NUM_RO_L   = (SEL_W + 1)'(NUM_RO);

  ro_state_e           r_state, w_state_next;
  logic [SEL_W-1:0]    r_sel, w_sel_new;
  logic [GATE_W-1:0]   r_gate;
  logic [TMR_W-1:0]    r_tmr;
  logic [CNT_W-1:0]    r_acc, w_acc_next;
  logic                r_acc_ovf, w_acc_ovf_next;
  logic [NUM_RO-1:0]   r_ro_en, w_en_new;
  logic [CNT_W-1:0]    r_count;
  logic [SEL_W-1:0]    r_count_idx;
  logic                r_overflow, r_sel_err;
  logic                w_start, w_sel_ok, w_load, w_capture;
  logic                w_sweep_req, w_sweep_more;
  logic                w_ro_mux, w_edge;

  assign w_start  = (r_state == ST_IDLE) && start;
  assign w_sel_ok = ({1'b0, ro_sel} < NUM_RO_L);

`ifdef RO_SWEEP_EN
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_RO - 1);
  logic r_sweep;

  assign w_sweep_req  = sweep;
  assign w_sweep_more = r_sweep && (r_sel != LAST_IDX);
  assign w_sel_new    = (r_state == ST_DONE) ? r_sel + SEL_W'(1)
                                             : (sweep ? '0 : ro_sel);
  assign sweep_done   = (r_state == ST_DONE) && r_sweep && (r_sel == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_sweep <= 1'b0;
    else if (w_start) r_sweep <= sweep;
  end
`else
  assign w_sweep_req  = 1'b0;
  assign w_sweep_more = 1'b0;
  assign w_sel_new    = ro_sel;
`endif

  // A new ring is enabled on an accepted valid start or on the next sweep index.
  assign w_load    = (w_start && (w_sweep_req || w_sel_ok)) ||
                     ((r_state == ST_DONE) && w_sweep_more);
  assign w_capture = ((r_state == ST_SETTLE) || (r_state == ST_GATE)) &&
                     (w_state_next == ST_DONE);

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (start) w_state_next = (w_sweep_req || w_sel_ok) ? ST_SETTLE : ST_DONE;
      ST_SETTLE: if (r_tmr == '0) w_state_next = (r_gate == '0) ? ST_DONE : ST_GATE;
      ST_GATE:   if (r_tmr == '0) w_state_next = ST_DONE;
      ST_DONE:   w_state_next = w_sweep_more ? ST_SETTLE : ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_en_new = '0;
    w_ro_mux = 1'b0;
    for (int i = 0; i < NUM_RO; i++) begin
      if (w_sel_new == SEL_W'(i)) w_en_new[i] = 1'b1;
      if (r_sel == SEL_W'(i))     w_ro_mux    = ro_in[i];
    end
  end

  ro_sync_edge u_sync_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (w_ro_mux),
    .rise (w_edge)
  );

  // Saturating edge accumulator; only the gate window contributes.
  always_comb begin
    w_acc_next     = r_acc;
    w_acc_ovf_next = r_acc_ovf;
    if ((r_state == ST_GATE) && w_edge) begin
      if (&r_acc) w_acc_ovf_next = 1'b1;
      else        w_acc_next     = r_acc + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= '0;
      r_gate      <= '0;
      r_tmr       <= '0;
      r_acc       <= '0;
      r_acc_ovf   <= 1'b0;
      r_ro_en     <= '0;
      r_count     <= '0;
      r_count_idx <= '0;
      r_overflow  <= 1'b0;
      r_sel_err   <= 1'b0;
    end else begin
      if (w_start) begin
        r_gate      <= gate_len;
        r_count     <= '0;
        r_overflow  <= 1'b0;
        r_count_idx <= w_sel_new;
        r_sel_err   <= !(w_sweep_req || w_sel_ok);
      end
      if (w_start || w_load) r_sel <= w_sel_new;

      if (w_load) begin
        r_tmr     <= TMR_W'(SETTLE_CYCLES - 1);
        r_acc     <= '0;
        r_acc_ovf <= 1'b0;
      end else begin
        if ((r_state == ST_SETTLE) && (r_tmr == '0)) r_tmr <= TMR_W'(r_gate) - TMR_ONE;
        else if (r_tmr != '0)                        r_tmr <= r_tmr - TMR_ONE;
        if (r_state == ST_GATE) begin
          r_acc     <= w_acc_next;
          r_acc_ovf <= w_acc_ovf_next;
        end
      end

      // The enable drops on the edge into DONE, so it is low for the whole done cycle.
      if (w_load)                         r_ro_en <= w_en_new;
      else if (w_state_next == ST_DONE)   r_ro_en <= '0;

      if (w_capture) begin
        r_count     <= w_acc_next;
        r_overflow  <= w_acc_ovf_next;
        r_count_idx <= r_sel;
      end
    end
  end

  assign ro_en     = r_ro_en;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign count     = r_count;
  assign count_idx = r_count_idx;
  assign overflow  = r_overflow;
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// Self-checking bench for ro_measure_ctrl; the sweep scenario is compiled in
// when RO_SWEEP_EN is defined.
`timescale 1ns/1ps
module tb_ro_measure_ctrl;

  localparam int NUM_RO = 8;
  localparam int SEL_W  = 4;   // wide enough to request index 9
  localparam int GATE_W = 16;
  localparam int CNT_W  = 8;   // small so saturation is reachable quickly
  localparam int SETTLE = 16;
  localparam int CLK_NS = 10;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b1;
  logic              start    = 1'b0;
  logic [SEL_W-1:0]  ro_sel   = '0;
  logic [GATE_W-1:0] gate_len = '0;
  logic [NUM_RO-1:0] ro_en;
  wire  [NUM_RO-1:0] ro_in;
  logic              busy, done, overflow, sel_err;
  logic [CNT_W-1:0]  count;
  logic [SEL_W-1:0]  count_idx;
`ifdef RO_SWEEP_EN
  logic              sweep = 1'b0;
  logic              sweep_done;
`endif

  int errors = 0;
  int checks = 0;
  int half_ns [NUM_RO];
  logic [NUM_RO-1:0] exp_mask = '0;
  int en_bad = 0, onehot_bad = 0, done_cnt = 0;

  ro_measure_ctrl #(
    .NUM_RO(NUM_RO), .SEL_W(SEL_W), .GATE_W(GATE_W),
    .CNT_W(CNT_W), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ro_sel   (ro_sel),
    .gate_len (gate_len),
`ifdef RO_SWEEP_EN
    .sweep    (sweep),
    .sweep_done(sweep_done),
`endif
    .ro_en    (ro_en),
    .ro_in    (ro_in),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .count_idx(count_idx),
    .overflow (overflow),
    .sel_err  (sel_err)
  );

  always #(CLK_NS / 2) clk = ~clk;

  // Oscillator bank model: a ring toggles only while its enable is high.
  for (genvar g = 0; g < NUM_RO; g++) begin : g_osc
    logic b = 1'b0;
    assign ro_in[g] = b;
    initial forever begin
      if (ro_en[g] !== 1'b1) begin
        b = 1'b0;
        @(ro_en[g]);
      end else begin
        #(half_ns[g]);
        b = (ro_en[g] === 1'b1) ? ~b : 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if ((ro_en & (ro_en - NUM_RO'(1))) != '0) onehot_bad++;
    if (ro_en != '0 && (ro_en & ~exp_mask) != '0) en_bad++;
    if (ro_en != '0 && !busy) en_bad++;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge count over a gate of glen clocks, for a square wave of period 2*half ns:
  // within one period of glen*CLK_NS/period, plus a clock of sampling slack.
  function automatic bit in_range(input int cnt, input int glen, input int half);
    int p, w;
    p = 2 * half;
    w = glen * CLK_NS;
    return (cnt * p >= w - p - CLK_NS) && (cnt * p <= w + p + CLK_NS);
  endfunction

  // Called #1 after a clock edge. Returns the number of edges after the
  // accepting edge T until done is visible (-1 on timeout). Done "at cycle
  // T+1+SETTLE+gate_len" is visible right after edge T+SETTLE+gate_len.
  task automatic run_meas(input int sel, input int glen, input int poke, output int lat);
    ro_sel   = SEL_W'(sel);
    gate_len = GATE_W'(glen);
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = -1;
    for (int k = 0; k < 3000; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (k == poke) begin
        start    = 1'b1;
        ro_sel   = SEL_W'(1);
        gate_len = GATE_W'(5);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, saved, d0, sel, glen;
    for (int i = 0; i < NUM_RO; i++) half_ns[i] = $urandom_range(40, 11);

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ro_en", ro_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_count_idx", count_idx, 0);
    check("rst_overflow", overflow, 0);
    check("rst_sel_err", sel_err, 0);
    rst_n = 1'b1;
    tick();

    // Nominal measurement: ring 2 at 40 ns period, 100-cycle gate -> ~25 edges
    half_ns[2] = 20;
    exp_mask   = 8'b0000_0100;
    run_meas(2, 100, -1, lat);
    check("a_latency", lat, SETTLE + 100);
    check("a_count_in_range", in_range(int'(count), 100, 20), 1);
    check("a_count_idx", count_idx, 2);
    check("a_overflow", overflow, 0);
    check("a_sel_err", sel_err, 0);
    check("a_busy_at_done", busy, 1);
    check("a_ro_en_at_done", ro_en, 0);
    tick();
    check("a_busy_after", busy, 0);
    check("a_done_after", done, 0);

    // Invalid index: immediate done, no enable ever
    exp_mask = '0;
    run_meas(9, 50, -1, lat);
    check("b_latency", lat, 0);
    check("b_sel_err", sel_err, 1);
    check("b_count", count, 0);
    check("b_count_idx", count_idx, 9);
    check("b_ro_en", ro_en, 0);
    tick();
    check("b_busy_after", busy, 0);

    // Saturation: ~275 edges into an 8-bit counter
    half_ns[5] = 20;
    exp_mask   = 8'b0010_0000;
    run_meas(5, 1100, -1, lat);
    check("c_latency", lat, SETTLE + 1100);
    check("c_count_sat", count, CNT_MAX);
    check("c_overflow", overflow, 1);
    check("c_sel_err", sel_err, 0);
    tick();

    // Start pulsed mid-gate and on the done cycle: both ignored
    half_ns[3] = 15;
    exp_mask   = 8'b0000_1000;
    d0 = done_cnt;
    run_meas(3, 60, 30, lat);
    check("d_latency", lat, SETTLE + 60);
    saved    = int'(count);
    ro_sel   = SEL_W'(4);
    gate_len = GATE_W'(10);
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    check("d_single_done", done_cnt - d0, 1);
    check("d_count_held", count, saved);
    check("d_count_idx", count_idx, 3);
    check("d_idle", busy, 0);
    check("d_count_in_range", in_range(saved, 60, 15), 1);

    // Zero-length gate
    exp_mask = 8'b0100_0000;
    run_meas(6, 0, -1, lat);
    check("e_latency", lat, SETTLE);
    check("e_count", count, 0);
    check("e_overflow", overflow, 0);
    tick();

    // Randomized measurements
    for (int r = 0; r < 6; r++) begin
      sel          = $urandom_range(NUM_RO - 1, 0);
      glen         = $urandom_range(300, 20);
      half_ns[sel] = $urandom_range(40, 11);
      exp_mask     = NUM_RO'(1) << sel;
      run_meas(sel, glen, -1, lat);
      check("r_latency", lat, SETTLE + glen);
      check("r_count_in_range", in_range(int'(count), glen, half_ns[sel]), 1);
      check("r_count_idx", count_idx, sel);
      tick();
    end

    // Reset in the middle of a gate
    half_ns[1] = 20;
    exp_mask   = 8'b0000_0010;
    ro_sel     = SEL_W'(1);
    gate_len   = GATE_W'(200);
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    check("g_ro_en_before", ro_en, 2);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("g_ro_en_async", ro_en, 0);
    check("g_busy_async", busy, 0);
    check("g_count_async", count, 0);
    check("g_count_idx_async", count_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) tick();
    check("g_no_done", done_cnt - d0, 0);
    check("g_idle", busy, 0);

`ifdef RO_SWEEP_EN
    // Sweep: all rings in order, one done each, sweep_done on the last
    begin
      int n;
      for (int i = 0; i < NUM_RO; i++) half_ns[i] = 11 + 4 * i;
      exp_mask = '1;
      n        = 0;
      sweep    = 1'b1;
      ro_sel   = SEL_W'(5);
      gate_len = GATE_W'(50);
      start    = 1'b1;
      tick();
      start = 1'b0;
      sweep = 1'b0;
      for (int k = 0; k < 1500 && n < NUM_RO; k++) begin
        if (done) begin
          check("s_count_idx", count_idx, n);
          check("s_count_in_range", in_range(int'(count), 50, half_ns[n]), 1);
          check("s_ro_en_at_done", ro_en, 0);
          check("s_sweep_done", sweep_done, (n == NUM_RO - 1) ? 1 : 0);
          n++;
        end else begin
          check("s_busy", busy, 1);
        end
        tick();
      end
      check("s_num_done", n, NUM_RO);
      check("s_idle_after", busy, 0);
    end
`endif

    check("ro_en_onehot", onehot_bad, 0);
    check("ro_en_expected_only", en_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
